// File: rtl/arb_mux_pkg.sv
// Shared types and the round-robin search used by arb_mux (optional lock feature: ARB_MUX_LOCK_EN).
package arb_mux_pkg;

   localparam int unsigned MAX_N     = 32;
   localparam int unsigned MAX_IDX_W = $clog2(MAX_N);

   typedef enum logic {
      OPEN   = 1'b0,
      LOCKED = 1'b1
   } lock_state_e;

   // One-hot grant of the first requester after ptr, searching modulo n.
   function automatic logic [MAX_N-1:0] rr_next(input int unsigned n,
                                                input int unsigned ptr,
                                                input logic [MAX_N-1:0] req);
      logic [MAX_N-1:0]     gnt;
      logic [MAX_IDX_W-1:0] idx;
      logic                 found;
      gnt   = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= MAX_N; k++) begin
         if (k <= n && !found) begin
            idx = MAX_IDX_W'((ptr + k) % n);
            if (req[idx]) begin
               gnt[idx] = 1'b1;
               found    = 1'b1;
            end
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus its encoded index.
module rr_arbiter
   import arb_mux_pkg::*;
#(
   parameter  int unsigned N     = 3,
   localparam int unsigned SEL_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [SEL_W-1:0] ptr_i,
   input  logic             enable_i,
   output logic [N-1:0]     grant_c_o,
   output logic [SEL_W-1:0] grant_idx_c_o
);

   logic [N-1:0] grant_c;

   always_comb begin
      grant_c = '0;
      if (enable_i) begin
         grant_c = N'(rr_next(N, 32'(ptr_i), MAX_N'(req_i)));
      end
   end

   always_comb begin
      grant_idx_c_o = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_c[i]) grant_idx_c_o = SEL_W'(i);
      end
   end

   assign grant_c_o = grant_c;

endmodule

// File: rtl/arb_mux.sv
// N-channel round-robin arbitrated mux with a one-entry registered output.
// Optional burst lock: ARB_MUX_LOCK_EN.
module arb_mux
   import arb_mux_pkg::*;
#(
   parameter  int unsigned WIDTH = 16,
   parameter  int unsigned N     = 3,
   localparam int unsigned SEL_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
`ifdef ARB_MUX_LOCK_EN
   input  logic [N-1:0]       in_last,
`endif
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_chan,
   input  logic               out_ready
);

   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   out_data_q,  out_data_d;
   logic [SEL_W-1:0]   out_chan_q,  out_chan_d;
   logic [SEL_W-1:0]   ptr_q,       ptr_d;

   logic [N-1:0]       req_c;
   logic [N-1:0]       grant_c;
   logic [SEL_W-1:0]   grant_idx_c;
   logic               load_ok_c;
   logic               xfer_c;
   logic               last_c;

`ifdef ARB_MUX_LOCK_EN
   lock_state_e        lock_q;
   logic [N-1:0]       lock_mask_q;

   // While locked only the owning channel may compete.
   always_comb begin
      req_c  = in_valid;
      if (lock_q == LOCKED) req_c = in_valid & lock_mask_q;
      last_c = |(in_last & grant_c);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_q      <= OPEN;
         lock_mask_q <= '0;
      end else if (xfer_c) begin
         case (lock_q)
            OPEN, LOCKED: begin
               if (last_c) begin
                  lock_q <= OPEN;
               end else begin
                  lock_q      <= LOCKED;
                  lock_mask_q <= grant_c;
               end
            end
            default: lock_q <= OPEN;
         endcase
      end
   end
`else
   always_comb begin
      req_c  = in_valid;
      last_c = 1'b1;
   end
`endif

   rr_arbiter #(.N(N)) u_rr_arbiter (
      .req_i         (req_c),
      .ptr_i         (ptr_q),
      .enable_i      (!rst),
      .grant_c_o     (grant_c),
      .grant_idx_c_o (grant_idx_c)
   );

   // Handshake and next-state of the output register and pointer.
   always_comb begin
      load_ok_c   = !out_valid_q || out_ready;
      in_ready    = grant_c & {N{load_ok_c}};
      xfer_c      = |in_ready;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      ptr_d       = ptr_q;
      if (xfer_c) begin
         out_valid_d = 1'b1;
         out_chan_d  = grant_idx_c;
         for (int i = 0; i < N; i++) begin
            if (grant_c[i]) out_data_d = in_data[i*WIDTH +: WIDTH];
         end
         if (last_c) ptr_d = grant_idx_c;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         ptr_q       <= SEL_W'(N - 1);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;

endmodule
